// File: rtl/clk_div_checker.sv
// Period and lock checker for the binary clock-divider outputs, sampled on clk.
// Optional cross-channel ripple check is compiled in with `define PHASE_CHECK_EN.
module clk_div_checker #(
  parameter int NCH        = 4,
  parameter int LOCK_COUNT = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] div_in,
  input  logic           err_clr,
  output logic [NCH-1:0] err,
  output logic           lock,
  output logic           toggle_seen
);

  localparam int CW = NCH + 1;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_COUNTING = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic [NCH-1:0] s;
  logic [NCH-1:0] s_d;
  logic [NCH-1:0] armed;
  logic [NCH-1:0] tog;
  logic [NCH-1:0] ev_per;
  logic [NCH-1:0] ev;
  logic           s_vld;
  logic           s_d_vld;
  logic           any_ev;
  logic [1:0]     state;
  logic [7:0]     good_cnt;

  // Toggles are masked until s_d holds real samples, so the reset value of
  // the samplers never looks like an edge and arming happens on a true edge.
  assign tog = s_d_vld ? (s ^ s_d) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      s       <= '0;
      s_d     <= '0;
      s_vld   <= 1'b0;
      s_d_vld <= 1'b0;
      armed   <= '0;
    end else begin
      s       <= div_in;
      s_d     <= s;
      s_vld   <= 1'b1;
      s_d_vld <= s_vld;
      armed   <= armed | tog;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    localparam logic [CW-1:0] HALF = CW'(1) << g;
    localparam logic [CW-1:0] SAT  = HALF + CW'(1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset)
        cnt <= '0;
      else if (tog[g])
        cnt <= CW'(1);
      else if (cnt != SAT)
        cnt <= cnt + CW'(1);
    end

    assign ev_per[g] = armed[g] & (tog[g] ? (cnt != HALF) : (cnt == SAT));
  end

`ifdef PHASE_CHECK_EN
  logic [NCH-1:0] ev_ph;

  assign ev_ph[0] = 1'b0;
  for (genvar g = 1; g < NCH; g++) begin : g_phase
    // A slower channel may only move on the cycle its faster neighbour falls.
    assign ev_ph[g] = armed[g] & armed[g-1] & tog[g] & ~(~s[g-1] & s_d[g-1]);
  end

  assign ev = ev_per | ev_ph;
`else
  assign ev = ev_per;
`endif

  assign any_ev = |ev;
  assign lock   = (state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      err         <= '0;
      toggle_seen <= 1'b0;
      state       <= ST_UNLOCKED;
      good_cnt    <= '0;
    end else begin
      err         <= (err & ~{NCH{err_clr}}) | ev;
      toggle_seen <= |tog;
      case (state)
        ST_UNLOCKED: begin
          good_cnt <= '0;
          if (&armed)
            state <= ST_COUNTING;
        end
        ST_COUNTING: begin
          if (any_ev) begin
            state    <= ST_UNLOCKED;
            good_cnt <= '0;
          end else if (tog[NCH-1]) begin
            if (good_cnt == 8'(LOCK_COUNT - 1))
              state <= ST_LOCKED;
            else
              good_cnt <= good_cnt + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (any_ev) begin
            state    <= ST_UNLOCKED;
            good_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_UNLOCKED;
          good_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_checker.sv
// Scoreboard bench for clk_div_checker: a timestamp-based reference model queues
// expected err/lock/toggle_seen per cycle, plus fixed checkpoints per scenario.
module tb_clk_div_checker;

  localparam int NCH        = 4;
  localparam int LOCK_COUNT = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] div_in;
  logic           err_clr;
  logic [NCH-1:0] err;
  logic           lock;
  logic           toggle_seen;

  always #5 clk = ~clk;

  clk_div_checker #(
    .NCH        (NCH),
    .LOCK_COUNT (LOCK_COUNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .div_in      (div_in),
    .err_clr     (err_clr),
    .err         (err),
    .lock        (lock),
    .toggle_seen (toggle_seen)
  );

  typedef struct packed {
    logic [NCH-1:0] err;
    logic           lock;
    logic           tseen;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: tracks the clk edge index of each channel's last toggle.
  logic [NCH-1:0] m_s, m_sd, m_armed, m_err;
  logic           m_v1, m_v2, m_lock, m_counting, m_tseen;
  int             m_good, m_n;
  int             m_last[NCH];

  task automatic model_step(input logic [NCH-1:0] d, input logic clr, input logic rst);
    logic [NCH-1:0] tog;
    logic [NCH-1:0] ev;
    exp_t e;
    if (rst) begin
      m_s = '0; m_sd = '0; m_v1 = 1'b0; m_v2 = 1'b0; m_armed = '0; m_err = '0;
      m_lock = 1'b0; m_counting = 1'b0; m_good = 0; m_tseen = 1'b0;
    end else begin
      tog = m_v2 ? (m_s ^ m_sd) : '0;
      ev  = '0;
      for (int i = 0; i < NCH; i++) begin
        int gap;
        gap = m_n - m_last[i];
        if (m_armed[i] && tog[i] && gap != (1 << i)) ev[i] = 1'b1;
        if (m_armed[i] && !tog[i] && gap > (1 << i)) ev[i] = 1'b1;
        if (tog[i]) m_last[i] = m_n;
      end
`ifdef PHASE_CHECK_EN
      for (int i = 0; i < NCH - 1; i++)
        if (m_armed[i] && m_armed[i+1] && tog[i+1] && !(m_sd[i] && !m_s[i]))
          ev[i+1] = 1'b1;
`endif
      if ((m_lock || m_counting) && ev != '0) begin
        m_lock = 1'b0; m_counting = 1'b0; m_good = 0;
      end else if (!m_lock && !m_counting) begin
        m_good = 0;
        if (m_armed == '1) m_counting = 1'b1;
      end else if (m_counting && tog[NCH-1]) begin
        m_good++;
        if (m_good == LOCK_COUNT) begin
          m_lock = 1'b1; m_counting = 1'b0;
        end
      end
      m_err   = (clr ? '0 : m_err) | ev;
      m_tseen = |tog;
      m_armed = m_armed | tog;
      m_sd    = m_s;
      m_s     = d;
      m_v2    = m_v1;
      m_v1    = 1'b1;
    end
    m_n++;
    e.err = m_err; e.lock = m_lock; e.tseen = m_tseen;
    sb.push_back(e);
  endtask

  int unsigned    c;
  logic [NCH-1:0] hold_mask, hold_val;
  bit             shift2;
  logic [31:0]    tmp;

  task automatic cycle(input logic clr, input logic rst);
    logic [NCH-1:0] d;
    logic [31:0]    cv, pv;
    exp_t e;
    cv = c;
    pv = c - 1;
    d  = cv[NCH-1:0];
    if (shift2) d[2] = pv[2];
    d = (d & ~hold_mask) | (hold_val & hold_mask);
    div_in  = d;
    err_clr = clr;
    reset   = rst;
    model_step(d, clr, rst);
    c++;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("err", err, e.err);
      check("lock", lock, e.lock);
      check("toggle_seen", toggle_seen, e.tseen);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  initial begin
    m_n = 0;
    for (int i = 0; i < NCH; i++) m_last[i] = 0;
    hold_mask = '0; hold_val = '0; shift2 = 1'b0; c = 0;
    div_in = '0; err_clr = 1'b0; reset = 1'b1;

    repeat (3) cycle(1'b0, 1'b1);
    check("rst_err", err, 0);
    check("rst_lock", lock, 0);
    check("rst_tseen", toggle_seen, 0);

    // Ideal divider from cycle 0
    c = 0;
    run(120);
    check("ideal_err", err, 0);
    check("ideal_lock", lock, 1);
    check("ideal_tseen", toggle_seen, 1);

    // div16 stuck
    tmp = c; hold_val = tmp[NCH-1:0]; hold_mask = 4'b1000;
    run(12);
    check("stuck3_err", err, 4'b1000);
    check("stuck3_lock", lock, 0);
    hold_mask = '0;
    run(40);
    cycle(1'b1, 1'b0);
    run(100);
    check("relock1_err", err, 0);
    check("relock1_lock", lock, 1);

    // Extra toggle on div4 right after its edge
    for (int k = 0; k < 4 && c[1:0] != 2'b11; k++) cycle(1'b0, 1'b0);
    tmp = ~c; hold_val = tmp[NCH-1:0]; hold_mask = 4'b0010;
    cycle(1'b0, 1'b0);
    hold_mask = '0;
    run(3);
    check("extra1_err1", err[1], 1);
    run(10);
    cycle(1'b1, 1'b0);
    run(100);
    check("relock2_err", err, 0);
    check("relock2_lock", lock, 1);

    // err_clr coinciding with an ongoing div8 timeout
    tmp = c; hold_val = tmp[NCH-1:0]; hold_mask = 4'b0100;
    run(8);
    cycle(1'b1, 1'b0);
    check("clr_vs_timeout_err2", err[2], 1);
    hold_mask = '0;
    run(100);
    check("locked_with_err2", err[2], 1);
    check("locked_with_err_lock", lock, 1);

    // Reset while locked, then restart at an arbitrary phase
    cycle(1'b0, 1'b1);
    check("midrst_err", err, 0);
    check("midrst_lock", lock, 0);
    c = $urandom;
    run(120);
    check("phase_any_err", err, 0);
    check("phase_any_lock", lock, 1);

    // Single missed div2 toggle
    tmp = ~c; hold_val = tmp[NCH-1:0]; hold_mask = 4'b0001;
    cycle(1'b0, 1'b0);
    hold_mask = '0;
    run(4);
    check("miss0_err0", err[0], 1);
    run(10);
    cycle(1'b1, 1'b0);
    run(30);
    check("miss0_clean", err, 0);

    // div8 shifted by one clk relative to div4
    shift2 = 1'b1;
    run(30);
    check("shift2_err2", err[2], 1);
    cycle(1'b1, 1'b0);
    run(40);
`ifdef PHASE_CHECK_EN
    check("shift2_settled_err2", err[2], 1);
`else
    check("shift2_settled_err2", err[2], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
